// File: rtl/cdb_rr_arbiter.sv
// Multi-lane common data bus: round-robin grant of up to CDB_WIDTH completed tags per
// cycle from NUM_FU execute units, each with a one-entry holding slot and stall back-pressure.
module cdb_rr_arbiter #(
  parameter int NUM_FU    = 4,
  parameter int CDB_WIDTH = 2,
  parameter int TAG_W     = 7
) (
  input  logic                       clock,
  input  logic                       reset_n,
  input  logic                       enable,
  input  logic                       flush,
  input  logic [NUM_FU-1:0]          ex_valid,
  input  logic [NUM_FU*TAG_W-1:0]    ex_tag,
  output logic [NUM_FU-1:0]          ex_stall,
  output logic [CDB_WIDTH*TAG_W-1:0] cdb_tag_out,
  output logic [CDB_WIDTH-1:0]       cdb_en_out,
  output logic                       busy
);

  localparam int PTR_W = $clog2(NUM_FU);

  logic [NUM_FU-1:0]          slot_v_q, slot_v_d;
  logic [NUM_FU*TAG_W-1:0]    slot_tag_q, slot_tag_d;
  logic [PTR_W-1:0]           rr_ptr_q, rr_ptr_d;
  logic [CDB_WIDTH-1:0]       cdb_en_q, cdb_en_d;
  logic [CDB_WIDTH*TAG_W-1:0] cdb_tag_q, cdb_tag_d;

  logic [NUM_FU-1:0]          cand_v;
  logic [NUM_FU*TAG_W-1:0]    cand_tag;
  logic [NUM_FU-1:0]          gnt;

  // A held slot always shadows the live input: it is the older result.
  always_comb begin
    cand_v   = '0;
    cand_tag = '0;
    for (int i = 0; i < NUM_FU; i++) begin
      cand_v[i] = slot_v_q[i] | ex_valid[i];
      cand_tag[i*TAG_W +: TAG_W] = slot_v_q[i] ? slot_tag_q[i*TAG_W +: TAG_W]
                                               : ex_tag[i*TAG_W +: TAG_W];
    end
  end

  always_comb begin
    int n_win;
    int idx;
    n_win     = 0;
    idx       = 0;
    gnt       = '0;
    cdb_en_d  = '0;
    cdb_tag_d = cdb_tag_q;
    rr_ptr_d  = rr_ptr_q;
    if (enable && !flush) begin
      for (int k = 0; k < NUM_FU; k++) begin
        idx = int'(rr_ptr_q) + k;
        if (idx >= NUM_FU) idx = idx - NUM_FU;
        if (cand_v[idx] && (n_win < CDB_WIDTH)) begin
          gnt[idx] = 1'b1;
          for (int l = 0; l < CDB_WIDTH; l++) begin
            if (l == n_win) begin
              cdb_en_d[l] = 1'b1;
              cdb_tag_d[l*TAG_W +: TAG_W] = cand_tag[idx*TAG_W +: TAG_W];
            end
          end
          n_win    = n_win + 1;
          rr_ptr_d = (idx == NUM_FU - 1) ? '0 : PTR_W'(idx + 1);
        end
      end
    end
  end

  // With enable low gnt is zero, so every live request lands in its slot.
  always_comb begin
    slot_v_d   = cand_v & ~gnt;
    slot_tag_d = cand_tag;
    if (flush) begin
      slot_v_d   = '0;
      slot_tag_d = slot_tag_q;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      slot_v_q   <= '0;
      slot_tag_q <= '0;
      rr_ptr_q   <= '0;
      cdb_en_q   <= '0;
      cdb_tag_q  <= '0;
    end else begin
      slot_v_q   <= slot_v_d;
      slot_tag_q <= slot_tag_d;
      rr_ptr_q   <= rr_ptr_d;
      cdb_en_q   <= cdb_en_d;
      cdb_tag_q  <= cdb_tag_d;
    end
  end

  assign ex_stall    = slot_v_q;
  assign cdb_en_out  = cdb_en_q;
  assign cdb_tag_out = cdb_tag_q;
  assign busy        = |cdb_en_q;

endmodule
